n64adv_ctrl_poller: RTL and testbench
=====================================

# n64adv_ctrl_poller

Joybus initiator that polls a standard N64 controller on its own, for boards where no console drives the controller line. On request it transmits the 8-bit status-read command plus host stop bit on the open-drain CTRL line, then times and decodes the controller's 32-bit reply. The reply is presented in the same bit layout the controller-sniffing path delivers to the NIOS II: button A at bit 0, Y axis at bits 31:24. The block runs in the CLK_4M domain, alongside the sniffer.

## Interface
Parameters:
- CMD, 8'h01, command byte, sent MSB first.
- CYC_US, 4, clock cycles per µs.
- RESP_TIMEOUT, 255, maximum cycles from release after host stop to the first reply falling edge.
- GUARD_CYC, 200, cycles the line stays released after a poll ends, before the next poll may start.

Ports:
- CLK_4M, in, 1, block clock.
- nSRST_4M, in, 1, reset. One clock; reset is asynchronous and active-low.
- poll_req, in, 1, single-cycle start pulse; ignored while busy=1.
- CTRL_I, in, 1, raw CTRL line level (asynchronous).
- CTRL_OE, out, 1, 1 = pull CTRL low; 0 = release (tri-state at top level).
- busy, out, 1, high from poll_req acceptance until the guard period ends.
- ctrl_data, out, 32, last valid reply; bit 0 = first received bit.
- data_valid, out, 1, one-cycle pulse when ctrl_data updates.
- timeout_err, out, 1, one-cycle pulse when a poll aborts.

## Operation
- CTRL_I passes through a 2-FF synchronizer, then a history register. A falling edge is prev=1, cur=0; a rising edge is prev=0, cur=1.
- Bit encoding (CYC_US=4, bit period 16 cycles):
  - '0' = 12 cycles low, then 4 cycles high.
  - '1' = 4 cycles low, then 12 cycles high.
  - Host stop bit = 4 cycles low, then release.
- States:
  - IDLE: poll_req goes to LINE_CHK.
  - LINE_CHK: count consecutive synced-high cycles; the count resets on low. At 16 cycles go to TX.
  - TX: 8 command bits, MSB first. Bit counter 0..7, phase counter 0..15. CTRL_OE=1 while phase < low length. After bit 7, go to TX_STOP.
  - TX_STOP: 4 cycles low, then release. Go to RX_WAIT.
  - RX_WAIT: wait for a falling edge. When the timeout counter exceeds RESP_TIMEOUT, go to ERR. Edges caused by the block's own drive are not counted.
  - RX: an 8-bit saturating counter resets on every edge.
    - On a rising edge, latch low_cnt.
    - On each falling edge after the first, decode bit = (low_cnt < high count) and shift right into a 32-bit shift register at bit 31.
    - The 32nd decode (stop-bit falling edge) goes to DONE.
    - If the counter saturates at 255 before 32 decodes, go to ERR.
  - DONE: ctrl_data <= shift register; pulse data_valid. Go to GUARD.
  - ERR: pulse timeout_err; ctrl_data unchanged. Go to GUARD.
  - GUARD: count GUARD_CYC cycles, then go to IDLE; busy drops in the same cycle.
- CTRL_OE is 0 in every state except TX and TX_STOP.
- poll_req while busy is dropped with no queueing.
- A line held low during LINE_CHK stalls the poll indefinitely; busy stays 1.

## Timing
- Reset values: CTRL_OE=0, busy=0, ctrl_data=0, data_valid=0, timeout_err=0. FSM returns to IDLE and all counters clear.
- Reset mid-TX releases the line asynchronously.
- poll_req in cycle n:
  - busy=1 at n+1.
  - First CTRL_OE=1 at n+17 with the line already high.
- TX+stop drive window is exactly 132 cycles.
- Synchronizer latency is 2 cycles. All RX thresholds apply to synced data.
- data_valid fires 1 cycle after the stop-bit falling edge is detected.
- Only registered outputs drive ports.

## Structure
- Shared header vh/n64adv_joybus.vh holds:
  - State encodings.
  - Bit-length constants (low-'0'=3 µs, low-'1'=1 µs, stop=1 µs, period=4 µs).
  - Default command value `CMD_STATUS_READ = 8'h01`.
- Input synchronizer: instance of the existing register_sync (reg_width 1, preset 1'b1).
- A natural sub-module is n64adv_joybus_bit_tx, the phase counter plus low-length compare that drives CTRL_OE.

## Test plan
- Reply of 0x00000001 (A pressed) after a 20-cycle delay -> one data_valid pulse; ctrl_data=32'h00000001; CTRL_OE pattern over 132 cycles encodes 0000_0001 + stop.
- Reply 32'hF0_10_8000 with X=8'h10, Y=8'hF0 -> ctrl_data=32'hF0108000; busy low GUARD_CYC cycles after DONE.
- No reply -> timeout_err pulse RESP_TIMEOUT+1 cycles after stop release; ctrl_data keeps its prior value.
- Reply stalls low after 10 bits -> timeout_err after 256 cycles; no data_valid.
- poll_req repeated while busy -> exactly one transaction; line held low 100 cycles before start -> CTRL_OE first asserts 16 synced-high cycles after release.
- nSRST_4M asserted mid-TX -> CTRL_OE=0 immediately; all outputs at reset values.

Source files
------------

// File: rtl/n64adv_ctrl_poller_pkg.sv
// rtl/n64adv_ctrl_poller_pkg.sv - Joybus poller state encodings and bit timing constants
package n64adv_ctrl_poller_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LINE_CHK,
    ST_TX,
    ST_TX_STOP,
    ST_RX_WAIT,
    ST_RX,
    ST_DONE,
    ST_ERR,
    ST_GUARD
  } poll_state_t;

  localparam logic [7:0] CMD_STATUS_READ = 8'h01;
  localparam int BIT_PERIOD_US = 4;
  localparam int LOW0_US       = 3;
  localparam int LOW1_US       = 1;
  localparam int STOP_US       = 1;

  function automatic int low_cycles(input logic b, input int cyc_us);
    return (b ? LOW1_US : LOW0_US) * cyc_us;
  endfunction

endpackage

// File: rtl/n64adv_joybus_bit_tx.sv
// rtl/n64adv_joybus_bit_tx.sv - serialises the command byte plus host stop bit onto CTRL_OE
module n64adv_joybus_bit_tx
  import n64adv_ctrl_poller_pkg::*;
#(
  parameter int CYC_US = 4
) (
  input  logic       CLK_4M,
  input  logic       nSRST_4M,
  input  logic       start,
  input  logic [7:0] cmd,
  output logic       oe,
  output logic       tx_last,
  output logic       stop_last
);

  localparam logic [7:0] PH_LAST   = 8'(BIT_PERIOD_US * CYC_US - 1);
  localparam logic [7:0] STOP_LEN  = 8'(STOP_US * CYC_US);
  localparam logic [7:0] STOP_LAST = 8'(STOP_US * CYC_US - 1);

  logic [7:0] phase;
  logic [7:0] phase_nxt;
  logic [7:0] low_len;
  logic [3:0] bit_idx;
  logic       active;

  assign tx_last   = active && (bit_idx == 4'd7) && (phase == PH_LAST);
  assign stop_last = active && (bit_idx == 4'd8) && (phase == STOP_LAST);

  // bit_idx 8 is the host stop bit; command bits go out MSB first
  always_comb begin
    phase_nxt = phase + 8'd1;
    if (bit_idx == 4'd8)
      low_len = STOP_LEN;
    else
      low_len = 8'(low_cycles(cmd[~bit_idx[2:0]], CYC_US));
  end

  always_ff @(posedge CLK_4M or negedge nSRST_4M) begin
    if (!nSRST_4M) begin
      phase   <= 8'd0;
      bit_idx <= 4'd0;
      active  <= 1'b0;
      oe      <= 1'b0;
    end else if (start) begin
      phase   <= 8'd0;
      bit_idx <= 4'd0;
      active  <= 1'b1;
      oe      <= 1'b1;
    end else if (active) begin
      if (stop_last) begin
        active <= 1'b0;
        oe     <= 1'b0;
      end else if (phase == PH_LAST) begin
        phase   <= 8'd0;
        bit_idx <= bit_idx + 4'd1;
        oe      <= 1'b1;
      end else begin
        phase <= phase_nxt;
        oe    <= (phase_nxt < low_len);
      end
    end
  end

endmodule

// File: rtl/register_sync.sv
// rtl/register_sync.sv - two-stage synchronizer with preset value on reset
module register_sync #(
  parameter int                   reg_width  = 1,
  parameter logic [reg_width-1:0] reg_preset = '0
) (
  input  logic                 clk,
  input  logic                 clk_en,
  input  logic                 nrst,
  input  logic [reg_width-1:0] reg_i,
  output logic [reg_width-1:0] reg_o
);

  logic [reg_width-1:0] reg_meta;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      reg_meta <= reg_preset;
      reg_o    <= reg_preset;
    end else if (clk_en) begin
      reg_meta <= reg_i;
      reg_o    <= reg_meta;
    end
  end

endmodule

// File: rtl/n64adv_ctrl_poller.sv
// rtl/n64adv_ctrl_poller.sv - standalone Joybus initiator polling an N64 controller for status
module n64adv_ctrl_poller
  import n64adv_ctrl_poller_pkg::*;
#(
  parameter logic [7:0] CMD          = CMD_STATUS_READ,
  parameter int         CYC_US       = 4,
  parameter int         RESP_TIMEOUT = 255,
  parameter int         GUARD_CYC    = 200
) (
  input  logic        CLK_4M,
  input  logic        nSRST_4M,
  input  logic        poll_req,
  input  logic        CTRL_I,
  output logic        CTRL_OE,
  output logic        busy,
  output logic [31:0] ctrl_data,
  output logic        data_valid,
  output logic        timeout_err
);

  localparam logic [15:0] LINE_LAST  = 16'(BIT_PERIOD_US * CYC_US - 1);
  localparam logic [15:0] RESP_LAST  = 16'(RESP_TIMEOUT);
  localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYC - 1);

  poll_state_t state;
  logic        ctrl_sync;
  logic        ctrl_prev;
  logic        fall;
  logic        rise;
  logic        tx_start;
  logic        tx_last;
  logic        stop_last;
  logic [15:0] tmr;
  logic [7:0]  rx_cnt;
  logic [7:0]  low_cnt;
  logic [4:0]  nbits;
  logic [31:0] shift;

  register_sync #(
    .reg_width (1),
    .reg_preset(1'b1)
  ) u_ctrl_sync (
    .clk   (CLK_4M),
    .clk_en(1'b1),
    .nrst  (nSRST_4M),
    .reg_i (CTRL_I),
    .reg_o (ctrl_sync)
  );

  always_ff @(posedge CLK_4M or negedge nSRST_4M) begin
    if (!nSRST_4M) ctrl_prev <= 1'b1;
    else           ctrl_prev <= ctrl_sync;
  end

  assign fall     = ctrl_prev & ~ctrl_sync;
  assign rise     = ~ctrl_prev & ctrl_sync;
  assign tx_start = (state == ST_LINE_CHK) && ctrl_sync && (tmr == LINE_LAST);

  n64adv_joybus_bit_tx #(
    .CYC_US(CYC_US)
  ) u_bit_tx (
    .CLK_4M   (CLK_4M),
    .nSRST_4M (nSRST_4M),
    .start    (tx_start),
    .cmd      (CMD),
    .oe       (CTRL_OE),
    .tx_last  (tx_last),
    .stop_last(stop_last)
  );

  always_ff @(posedge CLK_4M or negedge nSRST_4M) begin
    if (!nSRST_4M) begin
      state       <= ST_IDLE;
      tmr         <= 16'd0;
      rx_cnt      <= 8'd0;
      low_cnt     <= 8'd0;
      nbits       <= 5'd0;
      shift       <= 32'd0;
      busy        <= 1'b0;
      ctrl_data   <= 32'd0;
      data_valid  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (poll_req) begin
            state <= ST_LINE_CHK;
            busy  <= 1'b1;
            tmr   <= 16'd0;
          end
        end
        // a controller still holding the line keeps us here indefinitely
        ST_LINE_CHK: begin
          if (!ctrl_sync)
            tmr <= 16'd0;
          else if (tmr == LINE_LAST)
            state <= ST_TX;
          else
            tmr <= tmr + 16'd1;
        end
        ST_TX: begin
          if (tx_last) state <= ST_TX_STOP;
        end
        ST_TX_STOP: begin
          if (stop_last) begin
            state <= ST_RX_WAIT;
            tmr   <= 16'd0;
          end
        end
        // only falling edges start a reply; the release after our stop bit is a rising edge
        ST_RX_WAIT: begin
          if (fall) begin
            state  <= ST_RX;
            rx_cnt <= 8'd0;
            nbits  <= 5'd0;
          end else if (tmr == RESP_LAST) begin
            state       <= ST_ERR;
            timeout_err <= 1'b1;
          end else begin
            tmr <= tmr + 16'd1;
          end
        end
        ST_RX: begin
          if (rise) begin
            low_cnt <= rx_cnt;
            rx_cnt  <= 8'd0;
          end else if (fall) begin
            shift  <= {(low_cnt < rx_cnt), shift[31:1]};
            rx_cnt <= 8'd0;
            nbits  <= nbits + 5'd1;
            if (nbits == 5'd31) state <= ST_DONE;
          end else if (rx_cnt == 8'hFF) begin
            state       <= ST_ERR;
            timeout_err <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          ctrl_data  <= shift;
          data_valid <= 1'b1;
          state      <= ST_GUARD;
          tmr        <= 16'd0;
        end
        ST_ERR: begin
          state <= ST_GUARD;
          tmr   <= 16'd0;
        end
        ST_GUARD: begin
          if (tmr == GUARD_LAST) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            tmr <= tmr + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n64adv_ctrl_poller.sv
// tb/tb_n64adv_ctrl_poller.sv - randomized self-checking bench for n64adv_ctrl_poller
module tb_n64adv_ctrl_poller;

  localparam int RESP_TIMEOUT = 255;
  localparam int GUARD_CYC    = 200;
  localparam int LINE_CYC     = 16;
  localparam int PERIOD       = 16;
  localparam int TX_WIN       = 8 * PERIOD + 4;

  logic        CLK_4M   = 1'b0;
  logic        nSRST_4M = 1'b0;
  logic        poll_req = 1'b0;
  logic        dev_line = 1'b1;
  logic        CTRL_I;
  logic        CTRL_OE;
  logic        busy;
  logic [31:0] ctrl_data;
  logic        data_valid;
  logic        timeout_err;

  logic [7:0]  cmd_byte  = 8'h01;
  logic [31:0] last_data = 32'd0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int dv_cnt = 0, to_cnt = 0, dv_cyc = 0, to_cyc = 0;
  int busy_fall_cyc = 0, oe_rise_cyc = 0, oe_fall_cyc = 0, oe_hi_total = 0;
  logic busy_q = 1'b0, oe_q = 1'b0;

  // open-drain wire: either side may pull the line low
  assign CTRL_I = dev_line & ~CTRL_OE;

  n64adv_ctrl_poller dut (
    .CLK_4M     (CLK_4M),
    .nSRST_4M   (nSRST_4M),
    .poll_req   (poll_req),
    .CTRL_I     (CTRL_I),
    .CTRL_OE    (CTRL_OE),
    .busy       (busy),
    .ctrl_data  (ctrl_data),
    .data_valid (data_valid),
    .timeout_err(timeout_err)
  );

  always #5 CLK_4M = ~CLK_4M;

  always @(posedge CLK_4M) cyc <= cyc + 1;

  always @(negedge CLK_4M) begin
    if (data_valid) begin dv_cnt++; dv_cyc = cyc; end
    if (timeout_err) begin to_cnt++; to_cyc = cyc; end
    if (busy_q && !busy) busy_fall_cyc = cyc;
    if (!oe_q && CTRL_OE) oe_rise_cyc = cyc;
    if (oe_q && !CTRL_OE) oe_fall_cyc = cyc;
    if (CTRL_OE) oe_hi_total++;
    busy_q = busy;
    oe_q   = CTRL_OE;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK_4M);
    #1;
  endtask

  // expected CTRL_OE k cycles after the edge that accepted poll_req
  function automatic bit exp_oe_at(input int k);
    int j, b, p;
    if (k < LINE_CYC || k >= LINE_CYC + TX_WIN) return 1'b0;
    j = k - LINE_CYC;
    if (j >= 8 * PERIOD) return 1'b1;
    b = j / PERIOD;
    p = j % PERIOD;
    return p < (cmd_byte[7 - b] ? 4 : 12);
  endfunction

  function automatic int exp_oe_sum();
    int s = 0;
    for (int k = 0; k < 200; k++) s += int'(exp_oe_at(k));
    return s;
  endfunction

  task automatic do_poll(output int n);
    poll_req = 1'b1;
    tick();
    poll_req = 1'b0;
    n = cyc;
  endtask

  task automatic poll_and_check_tx(output int n);
    int errs = 0;
    int first_bad = -1;
    do_poll(n);
    chk_eq("busy_accept", busy, 1'b1);
    for (int k = 1; k <= LINE_CYC + TX_WIN; k++) begin
      tick();
      if (CTRL_OE !== exp_oe_at(k)) begin
        errs++;
        if (first_bad < 0) first_bad = k;
      end
    end
    chk_eq("oe_pattern_errs", errs, 0);
    if (errs != 0) $display("  first bad OE cycle offset %0d", first_bad);
  endtask

  task automatic send_reply(input logic [31:0] w, input int nbits, input bit stall, output int tf);
    int lo;
    for (int i = 0; i < nbits; i++) begin
      lo = (w[i] ? 4 : 12) + int'($urandom_range(0, 2)) - 1;
      dev_line = 1'b0;
      tf = cyc + 1;
      repeat (lo) tick();
      dev_line = 1'b1;
      repeat (PERIOD - lo) tick();
    end
    dev_line = 1'b0;
    tf = cyc + 1;
    if (!stall) begin
      repeat (8) tick();
      dev_line = 1'b1;
    end
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && busy; i++) tick();
    chk_eq("idle_reached", busy, 1'b0);
  endtask

  task automatic run_good(input logic [31:0] w, input int delay);
    int n, tf, dv0, to0;
    dv0 = dv_cnt;
    to0 = to_cnt;
    poll_and_check_tx(n);
    repeat (delay) tick();
    send_reply(w, 32, 1'b0, tf);
    wait_idle(800);
    chk_eq("dv_count", dv_cnt - dv0, 1);
    chk_eq("to_count_good", to_cnt - to0, 0);
    chk_eq("ctrl_data", ctrl_data, w);
    chk_eq("dv_time", dv_cyc, tf + 3);
    chk_eq("guard_after_done", busy_fall_cyc - dv_cyc, GUARD_CYC);
    last_data = w;
  endtask

  initial begin
    int n, tf, r, dv0, to0, oe0;
    logic [31:0] w;

    repeat (3) tick();
    chk_eq("rst_oe", CTRL_OE, 1'b0);
    chk_eq("rst_busy", busy, 1'b0);
    chk_eq("rst_data", ctrl_data, 32'd0);
    chk_eq("rst_dv", data_valid, 1'b0);
    chk_eq("rst_to", timeout_err, 1'b0);
    nSRST_4M = 1'b1;
    repeat (5) tick();

    run_good(32'h0000_0001, 20);
    run_good(32'hF010_8000, 35);
    for (int i = 0; i < 4; i++) run_good($urandom, int'($urandom_range(5, 100)));

    // no reply at all
    dv0 = dv_cnt;
    to0 = to_cnt;
    poll_and_check_tx(n);
    wait_idle(800);
    chk_eq("noreply_to_count", to_cnt - to0, 1);
    chk_eq("noreply_dv_count", dv_cnt - dv0, 0);
    chk_eq("noreply_to_time", to_cyc - oe_fall_cyc, RESP_TIMEOUT + 1);
    chk_eq("noreply_guard", busy_fall_cyc - to_cyc, GUARD_CYC + 1);
    chk_eq("noreply_data_kept", ctrl_data, last_data);

    // reply stalls low after 10 bits
    w = $urandom;
    dv0 = dv_cnt;
    to0 = to_cnt;
    poll_and_check_tx(n);
    repeat (15) tick();
    send_reply(w, 10, 1'b1, tf);
    wait_idle(800);
    chk_eq("stall_to_count", to_cnt - to0, 1);
    chk_eq("stall_dv_count", dv_cnt - dv0, 0);
    chk_eq("stall_to_time", to_cyc - tf, 2 + 256);
    chk_eq("stall_data_kept", ctrl_data, last_data);
    dev_line = 1'b1;
    repeat (5) tick();

    // repeated poll_req while busy
    to0 = to_cnt;
    oe0 = oe_hi_total;
    do_poll(n);
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(5, 40)) tick();
      if (busy) begin
        poll_req = 1'b1;
        tick();
        poll_req = 1'b0;
      end
    end
    wait_idle(800);
    repeat (60) tick();
    chk_eq("requeue_busy", busy, 1'b0);
    chk_eq("requeue_to_count", to_cnt - to0, 1);
    chk_eq("requeue_oe_cycles", oe_hi_total - oe0, exp_oe_sum());

    // line held low before the poll may start
    to0 = to_cnt;
    oe0 = oe_hi_total;
    dev_line = 1'b0;
    do_poll(n);
    repeat (100) tick();
    chk_eq("held_busy", busy, 1'b1);
    chk_eq("held_oe_cycles", oe_hi_total - oe0, 0);
    dev_line = 1'b1;
    r = cyc + 1;
    for (int i = 0; i < 60 && !CTRL_OE; i++) tick();
    chk_eq("held_oe_start", oe_rise_cyc - r, 2 + LINE_CYC - 1);
    wait_idle(800);
    chk_eq("held_to_count", to_cnt - to0, 1);

    // reset in the middle of the command
    do_poll(n);
    repeat (20) tick();
    chk_eq("pre_rst_oe", CTRL_OE, 1'b1);
    #1 nSRST_4M = 1'b0;
    #1;
    chk_eq("midrst_oe", CTRL_OE, 1'b0);
    chk_eq("midrst_busy", busy, 1'b0);
    chk_eq("midrst_data", ctrl_data, 32'd0);
    chk_eq("midrst_dv", data_valid, 1'b0);
    chk_eq("midrst_to", timeout_err, 1'b0);
    tick();
    tick();
    nSRST_4M = 1'b1;
    repeat (3) tick();
    run_good($urandom, 25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
